pause_fade: RTL and testbench

- Parametrised successor to the core pause block; sits between the core video output and arcade_video in every emu top.
- Merges several pause sources into one registered CPU pause.
- After a configurable idle timeout while paused, fades the RGB output in frame-paced steps down to 50%.
- Restores full brightness immediately on unpause.

---
 rtl/pause_fade_pkg.sv | 22 ++
 rtl/rgb_attenuator.sv | 48 ++++
 rtl/pause_fade.sv | 217 +++++++++++++++++++++
 tb/tb_pause_fade.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pause_fade_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pause_fade_pkg
//  Description : Shared types and constants for the pause/fade block.
//                FADE_MAX  - deepest fade level (8/16 = 50% brightness)
//                ATTEN_ONE - unity gain in the sixteenths scale
//  Revision    : 1.0 - initial release
// ============================================================================
package pause_fade_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSED  = 2'd1,
        DIMMING = 2'd2,
        DIMMED  = 2'd3
    } state_t;

    localparam int FADE_MAX  = 8;
    localparam int ATTEN_ONE = 16;

endpackage
`default_nettype wire

// File: rtl/rgb_attenuator.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_attenuator
//  Description : One colour channel scaled by (16 - level)/16, forced to zero
//                during blanking, registered with one cycle of latency.
//  Ports       : clk_sys - system clock
//                reset   - synchronous active-high reset (output -> 0)
//                value   - channel input, W bits
//                level   - fade level 0..8
//                blank   - hblank | vblank
//                atten   - registered attenuated channel
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_attenuator
    import pause_fade_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [W-1:0] value,
    input  logic [3:0]   level,
    input  logic         blank,
    output logic [W-1:0] atten
);

    logic [4:0]   w_scale;
    logic [W+4:0] w_prod;
    logic [W-1:0] w_scaled;

    // Level never exceeds 8, so the scale is always 8..16 and the
    // product never overflows W+5 bits.
    assign w_scale  = 5'(ATTEN_ONE) - {1'b0, level};
    assign w_prod   = (W+5)'(value) * (W+5)'(w_scale);
    assign w_scaled = W'(w_prod >> 4);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            atten <= '0;
        end else if (blank) begin
            atten <= '0;
        end else begin
            atten <= w_scaled;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pause_fade.sv
`default_nettype none
// ============================================================================
//  Module      : pause_fade
//  Description : Merges pause sources into one registered CPU pause and,
//                after an idle timeout while paused, fades the RGB output in
//                frame-paced steps down to 50%. Unpause restores brightness.
//  Ports       : clk_sys       - system clock
//                reset         - synchronous active-high reset
//                user_button   - pause toggle button (level)
//                pause_request - SRC external pause holds (level)
//                OSD_STATUS    - OSD open
//                options       - [0] pause on OSD, [1] dim enable
//                r, g, b       - video in
//                hblank,vblank - blanking
//                pause_cpu     - registered CPU pause
//                rgb_out       - {r,g,b} attenuated, 1-cycle latency
//                dim_level     - current fade level 0..8
//  Revision    : 1.0 - initial release
// ============================================================================
module pause_fade
    import pause_fade_pkg::*;
#(
    parameter int RW               = 8,
    parameter int GW               = 8,
    parameter int BW               = 8,
    parameter int CLK_HZ           = 24000000,
    parameter int DIM_TIMEOUT_S    = 10,
    parameter int FADE_STEP_FRAMES = 4,
    parameter int SRC              = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              user_button,
    input  logic [SRC-1:0]    pause_request,
    input  logic              OSD_STATUS,
    input  logic [1:0]        options,
    input  logic [RW-1:0]     r,
    input  logic [GW-1:0]     g,
    input  logic [BW-1:0]     b,
    input  logic              hblank,
    input  logic              vblank,
    output logic              pause_cpu,
    output logic [RW+GW+BW-1:0] rgb_out,
    output logic [3:0]        dim_level
);

    localparam int            PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] c_presc_max = PW'(CLK_HZ - 1);
    localparam logic [7:0]    c_timeout   = 8'(DIM_TIMEOUT_S);
    localparam logic [7:0]    c_step_last = 8'(FADE_STEP_FRAMES - 1);
    localparam logic [3:0]    c_fade_last = 4'(FADE_MAX - 1);

    logic          r_btn;
    logic          r_toggle;
    logic          r_vb;
    logic          w_req;
    logic          w_vb_rise;

    state_t        r_state,  w_state_nx;
    logic [PW-1:0] r_presc,  w_presc_nx;
    logic [7:0]    r_sec,    w_sec_nx;
    logic [7:0]    r_fc,     w_fc_nx;
    logic [3:0]    r_dim,    w_dim_nx;
    // Set when the fade is cancelled by clearing the dim enable; blocks a new
    // fade until the pause is released, since seconds stay at the timeout.
    logic          r_lock,   w_lock_nx;

    // Button history follows the pin even in reset so a button held through
    // reset is not seen as a fresh press afterwards.
    always_ff @(posedge clk_sys) begin
        r_btn <= user_button;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_toggle  <= 1'b0;
            pause_cpu <= 1'b0;
            r_vb      <= 1'b0;
        end else begin
            if (user_button && !r_btn) begin
                r_toggle <= ~r_toggle;
            end
            pause_cpu <= w_req;
            r_vb      <= vblank;
        end
    end

    assign w_req     = r_toggle | (|pause_request) | (options[0] & OSD_STATUS);
    assign w_vb_rise = vblank & ~r_vb;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= RUN;
            r_presc <= '0;
            r_sec   <= '0;
            r_fc    <= '0;
            r_dim   <= '0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_presc <= w_presc_nx;
            r_sec   <= w_sec_nx;
            r_fc    <= w_fc_nx;
            r_dim   <= w_dim_nx;
            r_lock  <= w_lock_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_sec_nx   = r_sec;
        w_fc_nx    = r_fc;
        w_dim_nx   = r_dim;
        w_lock_nx  = r_lock;

        // Unpause has priority over everything, including a vblank edge.
        if (!pause_cpu) begin
            w_state_nx = RUN;
            w_presc_nx = '0;
            w_sec_nx   = '0;
            w_fc_nx    = '0;
            w_dim_nx   = '0;
            w_lock_nx  = 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    w_state_nx = PAUSED;
                    w_presc_nx = '0;
                    w_sec_nx   = '0;
                end
                PAUSED: begin
                    if (r_presc == c_presc_max) begin
                        w_presc_nx = '0;
                        if (r_sec != 8'hFF) begin
                            w_sec_nx = r_sec + 8'd1;
                        end
                    end else begin
                        w_presc_nx = r_presc + PW'(1);
                    end
                    if ((r_sec == c_timeout) && options[1] && !r_lock) begin
                        w_state_nx = DIMMING;
                        w_fc_nx    = '0;
                    end
                end
                DIMMING: begin
                    if (!options[1]) begin
                        w_state_nx = PAUSED;
                        w_dim_nx   = '0;
                        w_fc_nx    = '0;
                        w_lock_nx  = 1'b1;
                    end else if (w_vb_rise) begin
                        if (r_fc == c_step_last) begin
                            w_fc_nx  = '0;
                            w_dim_nx = r_dim + 4'd1;
                            if (r_dim == c_fade_last) begin
                                w_state_nx = DIMMED;
                            end
                        end else begin
                            w_fc_nx = r_fc + 8'd1;
                        end
                    end
                end
                DIMMED: begin
                    if (!options[1]) begin
                        w_state_nx = PAUSED;
                        w_dim_nx   = '0;
                        w_lock_nx  = 1'b1;
                    end
                end
                default: begin
                    w_state_nx = RUN;
                end
            endcase
        end
    end

    assign dim_level = r_dim;

    logic         w_blank;
    logic [RW-1:0] w_r_att;
    logic [GW-1:0] w_g_att;
    logic [BW-1:0] w_b_att;

    assign w_blank = hblank | vblank;

    rgb_attenuator #(.W(RW)) u_att_r (
        .clk_sys (clk_sys),
        .reset   (reset),
        .value   (r),
        .level   (r_dim),
        .blank   (w_blank),
        .atten   (w_r_att)
    );

    rgb_attenuator #(.W(GW)) u_att_g (
        .clk_sys (clk_sys),
        .reset   (reset),
        .value   (g),
        .level   (r_dim),
        .blank   (w_blank),
        .atten   (w_g_att)
    );

    rgb_attenuator #(.W(BW)) u_att_b (
        .clk_sys (clk_sys),
        .reset   (reset),
        .value   (b),
        .level   (r_dim),
        .blank   (w_blank),
        .atten   (w_b_att)
    );

    assign rgb_out = {w_r_att, w_g_att, w_b_att};

endmodule
`default_nettype wire

// File: tb/tb_pause_fade.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pause_fade
//  Description : Scoreboard bench for pause_fade. Stimulus pushes expected
//                values tagged with the cycle they are due; a monitor on the
//                falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pause_fade;
    import pause_fade_pkg::*;

    localparam int K_PC  = 0;
    localparam int K_DIM = 1;
    localparam int K_RGB = 2;
    localparam int K_ST  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        user_button;
    logic [1:0]  pause_request;
    logic        OSD_STATUS;
    logic [1:0]  options;
    logic [7:0]  r, g, b;
    logic        hblank, vblank;
    logic        pause_cpu;
    logic [23:0] rgb_out;
    logic [3:0]  dim_level;

    pause_fade #(
        .RW(8), .GW(8), .BW(8),
        .CLK_HZ(100), .DIM_TIMEOUT_S(2), .FADE_STEP_FRAMES(1), .SRC(2)
    ) dut (
        .clk_sys       (clk),
        .reset         (reset),
        .user_button   (user_button),
        .pause_request (pause_request),
        .OSD_STATUS    (OSD_STATUS),
        .options       (options),
        .r             (r),
        .g             (g),
        .b             (b),
        .hblank        (hblank),
        .vblank        (vblank),
        .pause_cpu     (pause_cpu),
        .rgb_out       (rgb_out),
        .dim_level     (dim_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic string kname(input int k);
        case (k)
            K_PC:    return "pause_cpu";
            K_DIM:   return "dim_level";
            K_RGB:   return "rgb_out";
            default: return "state";
        endcase
    endfunction

    task automatic expect_at(input int dly, input int kind, input logic [31:0] val);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = val;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due <= cyc) begin
                case (q[i].kind)
                    K_PC:    act = {31'b0, pause_cpu};
                    K_DIM:   act = {28'b0, dim_level};
                    K_RGB:   act = {8'b0, rgb_out};
                    default: act = 32'(dut.r_state);
                endcase
                checks++;
                if (q[i].due != cyc || act !== q[i].exp) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got %0h expected %0h (due %0d)",
                             kname(q[i].kind), cyc, act, q[i].exp, q[i].due);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        reset = 1'b1; user_button = 1'b0; pause_request = 2'b00; OSD_STATUS = 1'b0;
        options = 2'b00; r = 8'hFF; g = 8'hFF; b = 8'hFF; hblank = 1'b0; vblank = 1'b0;

        // Reset state and first output after release
        tick(3);
        expect_at(0, K_RGB, 32'h0);
        reset = 1'b0;
        expect_at(1, K_RGB, 32'hFFFFFF);
        expect_at(1, K_PC, 0);
        expect_at(1, K_DIM, 0);
        expect_at(1, K_ST, 32'(RUN));
        tick(2);
        checks++;
        if (rgb_out !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL rgb_out after reset: got %0h", rgb_out);
        end
        checks++;
        if (pause_cpu !== 1'b0) begin
            errors++;
            $display("FAIL pause_cpu after reset: got %0b", pause_cpu);
        end

        // Held button toggles once, 2 cycles after the rise
        user_button = 1'b1;
        expect_at(1, K_PC, 0);
        expect_at(2, K_PC, 1);
        expect_at(49, K_PC, 1);
        tick(50);
        user_button = 1'b0;
        expect_at(3, K_PC, 1);
        expect_at(3, K_RGB, 32'hFFFFFF);
        tick(3);
        user_button = 1'b1;
        expect_at(1, K_PC, 1);
        expect_at(2, K_PC, 0);
        tick(1);
        user_button = 1'b0;
        tick(4);

        // Pause with dim enabled: timeout then eight fade steps
        options = 2'b10;
        user_button = 1'b1;
        tick(1);
        user_button = 1'b0;
        expect_at(202, K_ST, 32'(PAUSED));
        expect_at(203, K_ST, 32'(DIMMING));
        expect_at(203, K_DIM, 0);
        tick(210);
        for (int k = 1; k <= 8; k++) begin
            vblank = 1'b1;
            expect_at(1, K_DIM, 32'(k));
            expect_at(1, K_RGB, 32'h0);
            tick(2);
            vblank = 1'b0;
            if (k == 4) expect_at(1, K_RGB, 32'hBFBFBF);
            tick(2);
        end
        checks++;
        if (dim_level !== 4'd8) begin
            errors++;
            $display("FAIL dim_level after fade: got %0d", dim_level);
        end
        expect_at(0, K_ST, 32'(DIMMED));
        expect_at(0, K_RGB, 32'h7F7F7F);
        // Further frames hold the deepest level
        vblank = 1'b1;
        expect_at(1, K_DIM, 8);
        tick(2);
        vblank = 1'b0;
        tick(2);

        // Dim enable dropped: back to PAUSED, no re-dim while still paused
        options = 2'b00;
        expect_at(1, K_DIM, 0);
        expect_at(1, K_ST, 32'(PAUSED));
        tick(2);
        options = 2'b10;
        tick(300);
        checks++;
        if (dim_level !== 4'd0) begin
            errors++;
            $display("FAIL re-dim while paused: dim_level %0d", dim_level);
        end
        expect_at(0, K_DIM, 0);
        expect_at(0, K_ST, 32'(PAUSED));
        hblank = 1'b1;
        expect_at(1, K_RGB, 32'h0);
        tick(2);
        hblank = 1'b0;
        expect_at(1, K_RGB, 32'hFFFFFF);
        tick(2);

        // Unpause, re-pause, fade to level 5 then unpause mid-fade
        user_button = 1'b1;
        tick(1);
        user_button = 1'b0;
        tick(4);
        expect_at(0, K_PC, 0);
        expect_at(0, K_ST, 32'(RUN));
        user_button = 1'b1;
        tick(1);
        user_button = 1'b0;
        tick(210);
        for (int k = 1; k <= 5; k++) begin
            vblank = 1'b1;
            expect_at(1, K_DIM, 32'(k));
            tick(2);
            vblank = 1'b0;
            tick(2);
        end
        r = 8'h80;
        tick(2);
        expect_at(0, K_RGB, 32'h58AFAF);
        user_button = 1'b1;
        expect_at(1, K_PC, 1);
        expect_at(2, K_PC, 0);
        expect_at(2, K_DIM, 5);
        expect_at(2, K_ST, 32'(DIMMING));
        expect_at(3, K_DIM, 0);
        expect_at(3, K_ST, 32'(RUN));
        expect_at(3, K_RGB, 32'h58AFAF);
        expect_at(4, K_RGB, 32'h80FFFF);
        tick(1);
        user_button = 1'b0;
        tick(6);

        // External request lines and OSD gating
        options = 2'b00;
        pause_request = 2'b10;
        expect_at(1, K_PC, 1);
        tick(3);
        pause_request = 2'b00;
        expect_at(1, K_PC, 0);
        tick(2);
        pause_request = 2'b01;
        expect_at(1, K_PC, 1);
        tick(3);
        pause_request = 2'b00;
        tick(2);
        options = 2'b01;
        OSD_STATUS = 1'b1;
        expect_at(1, K_PC, 1);
        tick(3);
        options = 2'b00;
        expect_at(1, K_PC, 0);
        tick(2);
        OSD_STATUS = 1'b0;
        tick(2);
        checks++;
        if (pause_cpu !== 1'b0) begin
            errors++;
            $display("FAIL pause_cpu after OSD release: got %0b", pause_cpu);
        end

        // Button edge coinciding with reset is ignored
        reset = 1'b1;
        user_button = 1'b1;
        tick(3);
        reset = 1'b0;
        expect_at(2, K_PC, 0);
        expect_at(5, K_PC, 0);
        tick(6);
        user_button = 1'b0;
        tick(2);

        // Drain the scoreboard, bounded
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        while (q.size() != 0) begin
            errors++;
            $display("FAIL %s never checked: expected %0h (due %0d)",
                     kname(q[0].kind), q[0].exp, q[0].due);
            void'(q.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
